// File: rtl/reg_file_seq_if.sv
// Port bundle between the operand-fetch/write-back sequencer and its environment:
// instruction handshake, register-file read/write port and ALU start/done port.
interface reg_file_seq_if;
   logic              instr_valid;
   logic              instr_ready;
   logic [8:0]        instr;

   logic              rf_rd_en;
   logic [1:0]        rf_rd0_addr;
   logic [1:0]        rf_rd1_addr;
   logic signed [8:0] rf_rd0_data;
   logic signed [8:0] rf_rd1_data;

   logic              rf_wr_en;
   logic [1:0]        rf_wr_addr;
   logic signed [8:0] rf_wr_data;

   logic [2:0]        alu_op;
   logic signed [8:0] alu_a;
   logic signed [8:0] alu_b;
   logic              alu_start;
   logic              alu_done;
   logic signed [8:0] alu_result;

   // Sequencer side: initiates every register-file and ALU transaction.
   modport master (
      input  instr_valid, instr, rf_rd0_data, rf_rd1_data, alu_done, alu_result,
      output instr_ready, rf_rd_en, rf_rd0_addr, rf_rd1_addr,
             rf_wr_en, rf_wr_addr, rf_wr_data, alu_op, alu_a, alu_b, alu_start
   );

   modport slave (
      output instr_valid, instr, rf_rd0_data, rf_rd1_data, alu_done, alu_result,
      input  instr_ready, rf_rd_en, rf_rd0_addr, rf_rd1_addr,
             rf_wr_en, rf_wr_addr, rf_wr_data, alu_op, alu_a, alu_b, alu_start
   );
endinterface

// File: rtl/reg_file_seq.sv
// Operand-fetch / write-back sequencer for a 4x9-bit register file and an ALU
// with a start/done handshake; one instruction in flight at a time.
module reg_file_seq #(
   parameter int unsigned WATCHDOG_MAX = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   reg_file_seq_if.master        bus,
   output logic                  busy,
   output logic                  err,
   output logic [7:0]            retired
);

   localparam int          DATA_W   = 9;
   localparam logic [2:0]  OP_NOP   = 3'b000;
   localparam logic [2:0]  OP_LI    = 3'b111;
   localparam logic [7:0]  WD_LIMIT = 8'(WATCHDOG_MAX);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_START,
      S_WAIT,
      S_WB
   } state_t;

   function automatic logic signed [DATA_W-1:0] sext_imm(input logic [3:0] imm);
      return {{(DATA_W-4){imm[3]}}, imm};
   endfunction

   state_t                   r_state;
   logic [1:0]               r_rd;
   logic [7:0]               r_wdog;
   logic                     r_busy;
   logic                     r_err;
   logic [7:0]               r_retired;
   logic                     r_rd_en;
   logic [1:0]               r_rd0_addr;
   logic [1:0]               r_rd1_addr;
   logic                     r_wr_en;
   logic [1:0]               r_wr_addr;
   logic signed [DATA_W-1:0] r_wr_data;
   logic [2:0]               r_alu_op;
   logic signed [DATA_W-1:0] r_alu_a;
   logic signed [DATA_W-1:0] r_alu_b;
   logic                     r_alu_start;

   logic [2:0]               w_op;
   logic [1:0]               w_rd;
   logic [1:0]               w_rs;
   logic [1:0]               w_rt;

   assign w_op = bus.instr[8:6];
   assign w_rd = bus.instr[5:4];
   assign w_rs = bus.instr[3:2];
   assign w_rt = bus.instr[1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_rd        <= '0;
         r_wdog      <= '0;
         r_busy      <= 1'b0;
         r_err       <= 1'b0;
         r_retired   <= '0;
         r_rd_en     <= 1'b0;
         r_rd0_addr  <= '0;
         r_rd1_addr  <= '0;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_alu_op    <= '0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_start <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.instr_valid) begin
                  r_alu_op <= w_op;
                  r_rd     <= w_rd;
                  r_busy   <= 1'b1;
                  if (w_op == OP_NOP) begin
                     r_state <= S_WB;
                  end else if (w_op == OP_LI) begin
                     // Immediate is {rs,rt}; it goes straight to write-back.
                     r_state   <= S_WB;
                     r_wr_en   <= 1'b1;
                     r_wr_addr <= w_rd;
                     r_wr_data <= sext_imm(bus.instr[3:0]);
                  end else begin
                     r_state    <= S_READ;
                     r_rd_en    <= 1'b1;
                     r_rd0_addr <= w_rs;
                     r_rd1_addr <= w_rt;
                  end
               end
            end
            S_READ: begin
               // Operands are frozen here, so rd aliasing rs/rt sees the old value.
               r_alu_a     <= bus.rf_rd0_data;
               r_alu_b     <= bus.rf_rd1_data;
               r_rd_en     <= 1'b0;
               r_alu_start <= 1'b1;
               r_state     <= S_START;
            end
            S_START: begin
               r_alu_start <= 1'b0;
               r_wdog      <= '0;
               r_state     <= S_WAIT;
            end
            S_WAIT: begin
               if (bus.alu_done) begin
                  r_wr_en   <= 1'b1;
                  r_wr_addr <= r_rd;
                  r_wr_data <= bus.alu_result;
                  r_state   <= S_WB;
               end else if (r_wdog == WD_LIMIT) begin
                  r_err   <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_wdog <= r_wdog + 8'd1;
               end
            end
            S_WB: begin
               r_wr_en   <= 1'b0;
               r_retired <= r_retired + 8'd1;
               r_busy    <= 1'b0;
               r_state   <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Not ready while reset is held, ready in the first cycle after release.
   assign bus.instr_ready = (r_state == S_IDLE) && rst;
   assign bus.rf_rd_en    = r_rd_en;
   assign bus.rf_rd0_addr = r_rd0_addr;
   assign bus.rf_rd1_addr = r_rd1_addr;
   assign bus.rf_wr_en    = r_wr_en;
   assign bus.rf_wr_addr  = r_wr_addr;
   assign bus.rf_wr_data  = r_wr_data;
   assign bus.alu_op      = r_alu_op;
   assign bus.alu_a       = r_alu_a;
   assign bus.alu_b       = r_alu_b;
   assign bus.alu_start   = r_alu_start;

   assign busy    = r_busy;
   assign err     = r_err;
   assign retired = r_retired;

endmodule

// File: tb/tb_reg_file_seq.sv
// Directed bench for reg_file_seq: register-file and ALU models plus expectation
// queues for reads, ALU starts and write-backs, consumed by monitor processes.
module tb_reg_file_seq;

   localparam int WD = 20;

   typedef struct {int addr; int data; int cyc;} wr_t;
   typedef struct {int a0; int a1; int cyc;} rd_t;
   typedef struct {int op; int a; int b; int res; int d; int cyc;} alu_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       busy;
   logic       err;
   logic [7:0] retired;

   logic              tb_done   = 1'b0;
   logic              tb_glitch = 1'b0;
   logic signed [8:0] tb_result = '0;
   logic signed [8:0] rf [4];

   int cyc      = 0;
   int acc_cyc  = 0;
   int n_checks = 0;
   int n_errors = 0;
   int lat;

   wr_t  exp_wr[$];
   rd_t  exp_rd[$];
   alu_t exp_alu[$];

   reg_file_seq_if bus();

   reg_file_seq #(.WATCHDOG_MAX(WD)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus.master),
      .busy    (busy),
      .err     (err),
      .retired (retired)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign bus.rf_rd0_data = rf[bus.rf_rd0_addr];
   assign bus.rf_rd1_data = rf[bus.rf_rd1_addr];
   assign bus.alu_done    = tb_done | tb_glitch;
   assign bus.alu_result  = tb_result;

   always @(posedge clk) begin
      if (bus.rf_wr_en) rf[bus.rf_wr_addr] <= bus.rf_wr_data;
   end

   task automatic chk(input string nm, input int act, input int req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic fail_unexp(input string nm, input int a, input int b);
      n_checks++;
      n_errors++;
      $display("FAIL %s: got unexpected event (%0d,%0d), required none (t=%0t)", nm, a, b, $time);
   endtask

   // Write-back monitor
   always @(negedge clk) begin
      if (bus.rf_wr_en === 1'b1) begin
         if (exp_wr.size() == 0) begin
            fail_unexp("wr_unexpected", int'(bus.rf_wr_addr), int'(bus.rf_wr_data));
         end else begin
            wr_t e;
            e = exp_wr.pop_front();
            chk("wr_addr", int'(bus.rf_wr_addr), e.addr);
            chk("wr_data", int'(bus.rf_wr_data), e.data);
            chk("wr_cycle", cyc, e.cyc);
         end
      end
   end

   // Operand-read monitor
   always @(negedge clk) begin
      if (bus.rf_rd_en === 1'b1) begin
         if (exp_rd.size() == 0) begin
            fail_unexp("rd_unexpected", int'(bus.rf_rd0_addr), int'(bus.rf_rd1_addr));
         end else begin
            rd_t e;
            e = exp_rd.pop_front();
            chk("rd0_addr", int'(bus.rf_rd0_addr), e.a0);
            chk("rd1_addr", int'(bus.rf_rd1_addr), e.a1);
            chk("rd_cycle", cyc, e.cyc);
         end
      end
   end

   // ALU responder: checks the start pulse, then returns the result after e.d WAIT cycles
   initial begin
      forever begin
         @(negedge clk);
         if (bus.alu_start === 1'b1) begin
            if (exp_alu.size() == 0) begin
               fail_unexp("alu_unexpected", int'(bus.alu_a), int'(bus.alu_b));
            end else begin
               alu_t e;
               e = exp_alu.pop_front();
               chk("alu_op", int'(bus.alu_op), e.op);
               chk("alu_a", int'(bus.alu_a), e.a);
               chk("alu_b", int'(bus.alu_b), e.b);
               chk("alu_start_cycle", cyc, e.cyc);
               @(posedge clk); #1;
               chk("alu_start_pulse", int'(bus.alu_start), 0);
               if (e.d > 0) begin
                  repeat (e.d - 1) begin @(posedge clk); #1; end
                  tb_result = 9'(e.res);
                  tb_done   = 1'b1;
                  @(posedge clk); #1;
                  tb_done   = 1'b0;
               end
            end
         end
      end
   end

   task automatic issue(input logic [8:0] ins);
      int n = 0;
      while (!bus.instr_ready && n < 400) begin @(negedge clk); n++; end
      if (n >= 400) chk("issue_ready_timeout", n, 0);
      bus.instr_valid = 1'b1;
      bus.instr       = ins;
      @(posedge clk); #1;
      // cyc already counts the accept edge; label that edge cycle 0
      acc_cyc         = cyc - 1;
      bus.instr_valid = 1'b0;
   endtask

   task automatic wait_ready(output int l);
      int n = 0;
      @(negedge clk);
      while (!bus.instr_ready && n < 400) begin @(negedge clk); n++; end
      l = cyc - acc_cyc;
   endtask

   task automatic li(input int rd, input int imm, input int val);
      issue({3'b111, 2'(rd), 4'(imm)});
      exp_wr.push_back('{rd, val, acc_cyc + 1});
      wait_ready(lat);
      chk("li_ready_lat", lat, 2);
   endtask

   task automatic alu_op(input int op, input int rd, input int rs, input int rt,
                         input int a, input int b, input int res, input int d);
      issue({3'(op), 2'(rd), 2'(rs), 2'(rt)});
      exp_rd.push_back('{rs, rt, acc_cyc + 1});
      exp_alu.push_back('{op, a, b, res, d, acc_cyc + 2});
      if (d > 0) exp_wr.push_back('{rd, res, acc_cyc + 3 + d});
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required finish before %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      int acc1;
      bus.instr_valid = 1'b1;
      bus.instr       = 9'b111_10_01_10;

      // Reset held with a valid instruction offered
      repeat (3) @(negedge clk);
      chk("rst_ready", int'(bus.instr_ready), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_retired", int'(retired), 0);
      chk("rst_strobes", int'({bus.rf_rd_en, bus.rf_wr_en, bus.alu_start}), 0);
      chk("rst_alu_a", int'(bus.alu_a), 0);
      chk("rst_alu_b", int'(bus.alu_b), 0);
      chk("rst_alu_op", int'(bus.alu_op), 0);
      chk("rst_rf_addrs", int'({bus.rf_rd0_addr, bus.rf_rd1_addr, bus.rf_wr_addr}), 0);
      chk("rst_wr_data", int'(bus.rf_wr_data), 0);
      bus.instr_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("post_rst_ready", int'(bus.instr_ready), 1);
      chk("post_rst_retired", int'(retired), 0);

      // LI: +6 into R2, then the most negative immediate into R3
      li(2, 6, 6);
      li(3, 8, -8);
      chk("retired_after_li", int'(retired), 2);
      li(1, 5, 5);
      li(3, 14, -2);

      // R0 <= ALU(001, R1=5, R3=-2) = 3, done in the third WAIT cycle
      alu_op(1, 0, 1, 3, 5, -2, 3, 3);
      wait_ready(lat);
      chk("alu_ready_lat_d3", lat, 7);
      chk("retired_after_alu", int'(retired), 5);

      // Aliased op (rd=rs=rt=1) with done in first WAIT cycle, LI issued back-to-back
      alu_op(2, 1, 1, 1, 5, 5, 10, 1);
      acc1 = acc_cyc;
      wait_ready(lat);
      chk("alu_ready_lat_d1", lat, 5);
      issue(9'b111_10_1111);
      exp_wr.push_back('{2, -1, acc_cyc + 1});
      chk("b2b_accept_cycle", acc_cyc, acc1 + 5);
      wait_ready(lat);
      alu_op(3, 2, 1, 2, 10, -1, 9, 2);
      wait_ready(lat);
      chk("alu_ready_lat_d2", lat, 6);
      chk("retired_after_b2b", int'(retired), 8);

      // alu_done while idle is ignored
      tb_glitch = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_done_busy", int'(busy), 0);
      tb_glitch = 1'b0;

      // Watchdog abort: alu_done never returned
      alu_op(4, 3, 0, 2, 3, 9, 0, 0);
      wait_ready(lat);
      chk("wdog_ready_lat", lat, WD + 4);
      chk("wdog_err", int'(err), 1);
      chk("wdog_retired", int'(retired), 8);
      li(0, 7, 7);
      chk("wdog_next_retired", int'(retired), 9);
      chk("wdog_err_sticky", int'(err), 1);

      // Reset while waiting on the ALU
      alu_op(5, 0, 0, 0, 7, 7, 0, 0);
      repeat (4) @(posedge clk);
      #2;
      chk("midop_busy_before", int'(busy), 1);
      rst = 1'b0;
      #1;
      chk("midop_busy", int'(busy), 0);
      chk("midop_err", int'(err), 0);
      chk("midop_retired", int'(retired), 0);
      chk("midop_wr_en", int'(bus.rf_wr_en), 0);
      @(negedge clk);
      rst = 1'b1;

      // 256 NOPs: no reads or writes, retired wraps to 0
      for (int i = 0; i < 256; i++) begin
         issue(9'h000);
         wait_ready(lat);
         if (i == 0) begin
            chk("nop_ready_lat", lat, 2);
            chk("nop_retired_1", int'(retired), 1);
         end
         if (i == 254) chk("nop_retired_255", int'(retired), 255);
      end
      chk("nop_retired_wrap", int'(retired), 0);

      repeat (3) @(negedge clk);
      chk("exp_wr_drained", exp_wr.size(), 0);
      chk("exp_rd_drained", exp_rd.size(), 0);
      chk("exp_alu_drained", exp_alu.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
